mem_access_ctrl: RTL

Request/response front-end that sits directly upstream of the 16x32 single-port memory and is the only block driving its data, address and enable pins. It accepts single-word writes and wrapping read bursts of 1..16 words over a valid/ready handshake, and sequences the memory's one-cycle read latency. Read data is returned through a backpressured response channel, with last-beat and error flags.

---
 rtl/mem_access_ctrl_if.sv | 50 +++++
 rtl/mem_access_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module   : mem_access_ctrl_if
// Brief    : Request/response channel and memory pin bundle for mem_access_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_len;
    logic [DATA_WIDTH-1:0] req_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;
    logic                  rsp_err;

    logic [DATA_WIDTH-1:0] Mem_Data_in;
    logic [ADDR_WIDTH-1:0] Mem_Address;
    logic                  Mem_EN;
    logic [DATA_WIDTH-1:0] Mem_Data_out;
    logic                  Mem_Valid_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_data,
        output req_ready,
        output rsp_valid, rsp_data, rsp_last, rsp_err,
        input  rsp_ready,
        output Mem_Data_in, Mem_Address, Mem_EN,
        input  Mem_Data_out, Mem_Valid_out
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, req_data,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_last, rsp_err,
        output rsp_ready,
        input  Mem_Data_in, Mem_Address, Mem_EN,
        output Mem_Data_out, Mem_Valid_out
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Write / wrapping read-burst front-end for a single-port memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_RESP  = 3'd4
    } state_e;

    state_e                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic                  mem_en_q,    mem_en_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                  rsp_last_q,  rsp_last_d;
    logic                  rsp_err_q,   rsp_err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            wdata_q     <= '0;
            mem_en_q    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            mem_en_q    <= mem_en_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = bus.req_len;
                    wdata_d = bus.req_data;
                    state_d = bus.req_write ? S_WRITE : S_RD_ISSUE;
                end
            end
            S_WRITE:    state_d = S_IDLE;
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                // Memory output now reflects the address driven during RD_ISSUE.
                rsp_data_d  = bus.Mem_Data_out;
                rsp_err_d   = !bus.Mem_Valid_out;
                rsp_last_d  = (cnt_q == '0);
                rsp_valid_d = 1'b1;
                state_d     = S_RD_RESP;
            end
            S_RD_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - ADDR_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_RD_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the upcoming state so they line up with it.
        mem_en_d    = (state_d == S_WRITE);
        req_ready_d = (state_d == S_IDLE);
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.Mem_Data_in = wdata_q;
    assign bus.Mem_Address = addr_q;
    assign bus.Mem_EN      = mem_en_q;

endmodule

`default_nettype wire
